uart_frame_tx: RTL
==================

# uart_frame_tx

Byte-stream UART transmitter (8N1) with an input FIFO. It drives the serial line into the Nios system's rs232 RXD pin, so FPGA-side logic or a controller board can send game commands and button events to the party-game software. It is the transmitting end of the same serial link that the system's rs232 receiver terminates. Bytes are written through a valid/ready handshake and serialized LSB-first at a fixed baud rate derived from the system clock.

## Interface
- CLK_HZ, 50000000, system clock frequency in Hz
- BAUD, 115200, line rate in bit/s
- FIFO_DEPTH, 8, byte FIFO depth; power of two, at least 2
- DIV (localparam), (CLK_HZ + BAUD/2) / BAUD, clocks per bit; 434 at the defaults
- clk  in  1  system clock; all logic is on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_data  in  8  byte to send
- wr_valid  in  1  wr_data is offered this cycle
- wr_ready  out  1  FIFO can accept a byte; equals !full
- txd  out  1  serial line; idles high; connects to the rs232 RXD of the receiving end
- busy  out  1  high while a frame is on the line or the FIFO is non-empty
- fifo_count  out  $clog2(FIFO_DEPTH+1)  number of bytes queued, excluding the byte being shifted

## Operation
- Reset, asynchronous, active-low. While reset_n is low, and in the cycle after it rises:
  - state IDLE; FIFO empty (fifo_count=0)
  - txd=1, busy=0, wr_ready=1
  - baud counter and bit index are 0
- Reset mid-frame aborts the frame. txd returns to 1 immediately and the truncated frame is not resumed.
- Push: a byte is written on an edge where wr_valid && wr_ready. wr_valid while wr_ready=0 is ignored and the byte is not stored. Writers must hold wr_valid and wr_data until they see wr_ready.
- Full: wr_ready=0 whenever fifo_count==FIFO_DEPTH, even if a pop happens in the same cycle.
- Simultaneous push and pop leave fifo_count unchanged. Data order is strict FIFO, and pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If the FIFO is non-empty, pop the head into an 8-bit shift register, clear the baud counter, and go to START.
  - START: txd=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for DIV cycles per bit, then shift right. The bit index counts 0..7. After bit 7's DIV cycles, go to STOP.
  - STOP: txd=1 for DIV cycles. At the end of STOP, if the FIFO is non-empty, pop and go directly to START with no idle cycle. Otherwise go to IDLE.
- The baud counter counts 0..DIV-1 and wraps. A bit period ends on the cycle where the counter equals DIV-1.
- The frame is exactly 10*DIV clocks: start bit, 8 data bits LSB first, 1 stop bit. There is no parity.
- txd is driven from a register and is glitch-free.
- busy = (state != IDLE) || (fifo_count != 0).

## Timing
- Write accepted at edge N into an empty FIFO with FSM in IDLE:
  - fifo_count=1 after edge N
  - pop at edge N+1; fifo_count=0 and txd=0 after edge N+1
- Start bit: txd low for exactly DIV cycles (edges N+1 to N+1+DIV).
- Data bit k is valid from edge N+1+(k+1)*DIV, for DIV cycles.
- Stop bit: txd high from edge N+1+9*DIV. The frame ends at edge N+1+10*DIV.
- Back-to-back frames: the next start bit begins on the same edge the previous stop bit ends. Sustained throughput is 1 byte per 10*DIV clocks.
- wr_ready is combinational from fifo_count only. wr_valid has no combinational path to wr_ready.

## Test plan
- Reset with reset_n=0 held for 3 cycles, then release -> txd=1, wr_ready=1, busy=0, fifo_count=0, with no edges on txd for 5000 cycles.
- Write 0x55 once, defaults (DIV=434) -> txd low after edge N+1; line reads 0,1,0,1,0,1,0,1,0,1, each level held 434 cycles; busy falls at N+1+4340.
- Write 0xA3, 0x00, 0xFF on consecutive cycles -> three frames are contiguous with no gap between stop and next start bit; a receiver model decodes A3, 00, FF.
- Write 9 bytes back-to-back with wr_valid held high:
  - fifo_count reaches 8 and wr_ready drops to 0
  - the 10th offered byte stalls until the next pop
  - all bytes arrive in order with none lost or duplicated
- Push and pop in the same cycle with fifo_count=3 -> fifo_count stays 3 and wrap-around ordering is preserved across 20 bytes.
- Assert reset_n=0 during data bit 4 of 0x0F -> txd=1 immediately and fifo_count=0; after release, write 0x81 -> one clean frame for 0x81 only.

Source files
------------

// File: rtl/uart_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_tx
// Purpose  : 8N1 UART transmitter with a byte FIFO. Bytes are accepted via a
//            valid/ready handshake and sent LSB-first at a fixed baud rate
//            derived from the system clock (DIV clocks per bit).
// Ports    : clk        - system clock, rising edge
//            reset_n    - asynchronous active-low reset
//            wr_data    - byte to send
//            wr_valid   - wr_data offered this cycle
//            wr_ready   - FIFO can accept a byte (!full)
//            txd        - registered serial line, idles high
//            busy       - frame on the line or bytes queued
//            fifo_count - bytes queued, excluding the byte being shifted
// Revision : 1.0  initial release
// ============================================================================
module uart_frame_tx #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [7:0]                         wr_data,
    input  logic                               wr_valid,
    output logic                               wr_ready,
    output logic                               txd,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int DIV     = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  BAUD_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);
    localparam logic [FCNT_W-1:0] FCNT_FULL = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] count;
    logic              push;
    logic              pop;
    logic              fifo_nonempty;

    // Full is judged on the registered count only, so a pop in the same
    // cycle never opens a slot early and wr_valid never reaches wr_ready.
    assign wr_ready      = (count != FCNT_FULL);
    assign push          = wr_valid && wr_ready;
    assign fifo_nonempty = (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + FCNT_ONE;
                2'b01:   count <= count - FCNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic             txd_reg;
    logic             txd_next;
    logic             bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            txd_reg  <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
            txd_reg  <= txd_next;
        end
    end

    // txd_next is the line level for the state being entered, so the line
    // comes straight from a flop and changes exactly on bit boundaries.
    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        txd_next      = txd_reg;
        pop           = 1'b0;

        if (state != IDLE) begin
            baud_cnt_next = bit_end ? '0 : (baud_cnt + BAUD_ONE);
        end

        case (state)
            IDLE: begin
                txd_next = 1'b1;
                if (fifo_nonempty) begin
                    pop           = 1'b1;
                    shift_next    = mem[rd_ptr];
                    baud_cnt_next = '0;
                    txd_next      = 1'b0;
                    state_next    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_idx_next = '0;
                    txd_next     = shift[0];
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        txd_next   = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        shift_next   = {1'b0, shift[7:1]};
                        txd_next     = shift[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when data waits.
                    if (fifo_nonempty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        txd_next   = 1'b0;
                        state_next = START;
                    end else begin
                        txd_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign txd        = txd_reg;
    assign busy       = (state != IDLE) || fifo_nonempty;
    assign fifo_count = count;

endmodule
`default_nettype wire
